// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    // Opcodes (IR[31:26]) handled by the control unit
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // FSM state encodings; 12-15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    // ALUSrcB
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    // PCSource
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full control vector driven towards the datapath
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control decode for the multicycle control FSM.
// Latency: purely combinational.
// Backpressure: FETCH load strobes are held off until mem_ready.
// Ports: state/opcode/mem_ready in; ctrl vector and illegal-opcode flag out.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       illegal_op
);

    always_comb begin
        ctrl       = '0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC only load once the fetched word is actually there
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SEXT_SH;
                ctrl.alu_op    = ALUOP_ADD;
                illegal_op     = !is_legal_op(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADDI;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath plus retired-instruction counter.
// Latency: outputs are decoded from the state register in the same cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready.
// Ports: clock/reset_n, opcode/zero/mem_ready in; datapath strobes, mux selects,
//        state (debug), illegal_op pulse and instr_count out.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int OP_W  = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               retire;
    logic [5:0]         op;
    ctrl_t              ctrl_raw, ctrl;
    logic               illegal_raw;
    // zero is combined with pc_write_cond in the datapath, not here
    logic               unused_zero;

    assign op          = opcode[5:0];
    assign unused_zero = zero;

    mc_ctrl_decode u_decode (
        .state      (state_q),
        .opcode     (op),
        .mem_ready  (mem_ready),
        .ctrl       (ctrl_raw),
        .illegal_op (illegal_raw)
    );

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH; // illegal: dropped, not retired
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  retire  = 1'b1;
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
                retire  = mem_ready;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    retire  = 1'b1;
            S_BRANCH: retire  = 1'b1;
            S_JUMP:   retire  = 1'b1;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: retire  = 1'b1;
            default:  state_d = S_FETCH;
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The state register already sits in FETCH during reset, so the FETCH
    // strobes must be masked here to keep memory and IR quiet.
    assign ctrl = reset_n ? ctrl_raw : '0;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;
    assign illegal_op    = reset_n & illegal_raw;
    assign instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle directed vectors with
// hand-computed state/count, control expectations from the state table.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multicycle_control #(.CNT_W(32), .OP_W(6)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .illegal_op    (illegal_op),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        rdy;
        logic [5:0]  op;
        logic        z;
        logic [3:0]  st;
        logic [31:0] cnt;
        logic        ill;
    } vec_t;

    typedef struct {
        string       name;
        int          idx;
        logic [3:0]  st;
        logic [31:0] cnt;
        logic        ill;
        logic [15:0] cv;
        logic [15:0] cm;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, idx, got, want);
        end
    endtask

    task automatic add_v(input string name, input logic rst_n, input logic rdy, input logic [5:0] op,
                         input logic z, input logic [3:0] st, input logic [31:0] cnt, input logic ill);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.rdy = rdy; v.op = op; v.z = z;
        v.st = st; v.cnt = cnt; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Expected control vector {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
    // and the mask of bits that are defined in that state (strobes always defined).
    function automatic void spec_ctrl(input logic rst_n, input logic [3:0] st, input logic rdy,
                                      output logic [15:0] v, output logic [15:0] m);
        v = 16'h0000;
        m = 16'hDC80;
        if (!rst_n) begin
            m = 16'hFFFF;
        end else begin
            case (st)
                4'd0:  begin v[12] = 1'b1; v[5:4] = 2'b01; v[10] = rdy; v[15] = rdy; m |= 16'h207F; end
                4'd1:  begin v[5:4] = 2'b11; m |= 16'h007C; end
                4'd2:  begin v[6] = 1'b1; v[5:4] = 2'b10; m |= 16'h007C; end
                4'd3:  begin v[12] = 1'b1; v[13] = 1'b1; m |= 16'h2000; end
                4'd4:  begin v[7] = 1'b1; v[9] = 1'b1; m |= 16'h0300; end
                4'd5:  begin v[11] = 1'b1; v[13] = 1'b1; m |= 16'h2000; end
                4'd6:  begin v[6] = 1'b1; v[3:2] = 2'b10; m |= 16'h007C; end
                4'd7:  begin v[7] = 1'b1; v[8] = 1'b1; m |= 16'h0300; end
                4'd8:  begin v[6] = 1'b1; v[3:2] = 2'b01; v[14] = 1'b1; v[1:0] = 2'b01; m |= 16'h007F; end
                4'd9:  begin v[15] = 1'b1; v[1:0] = 2'b10; m |= 16'h0003; end
                4'd10: begin v[6] = 1'b1; v[5:4] = 2'b10; v[3:2] = 2'b11; m |= 16'h007C; end
                4'd11: begin v[7] = 1'b1; m |= 16'h0300; end
                default: ;
            endcase
        end
    endfunction

    // Monitor: pops one expectation per presented cycle and compares
    initial begin
        exp_t        e;
        logic [15:0] got_cv;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_cv = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
                check({e.name, ".state"}, e.idx, 32'(state), 32'(e.st));
                check({e.name, ".count"}, e.idx, instr_count, e.cnt);
                check({e.name, ".illegal"}, e.idx, 32'(illegal_op), 32'(e.ill));
                check({e.name, ".ctrl"}, e.idx, 32'(got_cv & e.cm), 32'(e.cv & e.cm));
                check({e.name, ".rd_wr_excl"}, e.idx, 32'(mem_read & mem_write), 32'd0);
            end
        end
    end

    // Stimulus
    initial begin
        exp_t e;
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;

        //     name        rst rdy  op     z  state cnt ill
        add_v("rst",       0, 1, 6'h00, 0, 4'd0,  0, 0);
        add_v("rst",       0, 1, 6'h00, 0, 4'd0,  0, 0);
        add_v("r_fetch",   1, 1, 6'h00, 0, 4'd0,  0, 0);
        add_v("r_decode",  1, 1, 6'h00, 0, 4'd1,  0, 0);
        add_v("r_exec",    1, 1, 6'h3F, 0, 4'd6,  0, 0);
        add_v("r_wb",      1, 1, 6'h3F, 0, 4'd7,  0, 0);
        add_v("f_wait",    1, 0, 6'h3F, 0, 4'd0,  1, 0);
        add_v("f_wait",    1, 0, 6'h3F, 0, 4'd0,  1, 0);
        add_v("lw_fetch",  1, 1, 6'h23, 0, 4'd0,  1, 0);
        add_v("lw_decode", 1, 1, 6'h23, 0, 4'd1,  1, 0);
        add_v("lw_adr",    1, 1, 6'h23, 0, 4'd2,  1, 0);
        add_v("lw_rd_w",   1, 0, 6'h23, 0, 4'd3,  1, 0);
        add_v("lw_rd_w",   1, 0, 6'h23, 0, 4'd3,  1, 0);
        add_v("lw_rd_w",   1, 0, 6'h23, 0, 4'd3,  1, 0);
        add_v("lw_rd",     1, 1, 6'h23, 0, 4'd3,  1, 0);
        add_v("lw_wb",     1, 1, 6'h23, 0, 4'd4,  1, 0);
        add_v("sw_fetch",  1, 1, 6'h2B, 0, 4'd0,  2, 0);
        add_v("sw_decode", 1, 1, 6'h2B, 0, 4'd1,  2, 0);
        add_v("sw_adr",    1, 1, 6'h2B, 0, 4'd2,  2, 0);
        add_v("sw_wr_w",   1, 0, 6'h23, 0, 4'd5,  2, 0);
        add_v("sw_wr",     1, 1, 6'h23, 0, 4'd5,  2, 0);
        add_v("bz_fetch",  1, 1, 6'h04, 1, 4'd0,  3, 0);
        add_v("bz_decode", 1, 1, 6'h04, 1, 4'd1,  3, 0);
        add_v("bz_branch", 1, 1, 6'h04, 1, 4'd8,  3, 0);
        add_v("bn_fetch",  1, 1, 6'h04, 0, 4'd0,  4, 0);
        add_v("bn_decode", 1, 1, 6'h04, 0, 4'd1,  4, 0);
        add_v("bn_branch", 1, 1, 6'h04, 0, 4'd8,  4, 0);
        add_v("j_fetch",   1, 1, 6'h02, 0, 4'd0,  5, 0);
        add_v("j_decode",  1, 1, 6'h02, 0, 4'd1,  5, 0);
        add_v("j_jump",    1, 1, 6'h02, 0, 4'd9,  5, 0);
        add_v("ai_fetch",  1, 1, 6'h08, 0, 4'd0,  6, 0);
        add_v("ai_decode", 1, 1, 6'h08, 0, 4'd1,  6, 0);
        add_v("ai_ex",     1, 1, 6'h08, 0, 4'd10, 6, 0);
        add_v("ai_wb",     1, 1, 6'h08, 0, 4'd11, 6, 0);
        add_v("il_fetch",  1, 1, 6'h3F, 0, 4'd0,  7, 0);
        add_v("il_decode", 1, 1, 6'h3F, 0, 4'd1,  7, 1);
        add_v("il_after",  1, 1, 6'h23, 0, 4'd0,  7, 0);
        add_v("ab_decode", 1, 1, 6'h23, 0, 4'd1,  7, 0);
        add_v("ab_adr",    1, 1, 6'h23, 0, 4'd2,  7, 0);
        add_v("ab_rd_w",   1, 0, 6'h23, 0, 4'd3,  7, 0);
        add_v("ab_rst",    0, 1, 6'h23, 0, 4'd0,  0, 0);
        add_v("ab_fwait",  1, 0, 6'h23, 0, 4'd0,  0, 0);
        add_v("ab_fetch",  1, 1, 6'h00, 0, 4'd0,  0, 0);
        add_v("ab_decode2",1, 1, 6'h00, 0, 4'd1,  0, 0);

        @(posedge clock); #1;
        foreach (vecs[i]) begin
            reset_n   = vecs[i].rst_n;
            mem_ready = vecs[i].rdy;
            opcode    = vecs[i].op;
            zero      = vecs[i].z;
            e.name = vecs[i].name;
            e.idx  = i;
            e.st   = vecs[i].st;
            e.cnt  = vecs[i].cnt;
            e.ill  = vecs[i].ill;
            spec_ctrl(vecs[i].rst_n, vecs[i].st, vecs[i].rdy, e.cv, e.cm);
            exp_q.push_back(e);
            @(posedge clock); #1;
        end
        repeat (2) @(negedge clock);
        check("drain", 0, 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
